program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have parameter D, default 12, meaning instruction-memory address width.
REQ-002 SHALL have parameter W, default 9, meaning instruction word width.
REQ-003 SHALL have ports, in this order:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level, sampled each clk; begins load-then-run from IDLE or HALT.
- load_valid  in  1  program word offered.
- load_data  in  W  program word.
- load_last  in  1  qualifies final word of program.
- load_ready  out  1  sequencer accepts word.
- mem_we  out  1  instruction-memory write enable.
- mem_waddr  out  D  write address.
- mem_wdata  out  W  write data.
- programCounter  out  D  fetch address to instruction memory.
- machineCode  in  W  combinational read data at programCounter.
- branch_taken  in  1  redirect request from datapath.
- branch_target  in  D  redirect address.
- stall  in  1  freeze fetch.
- busy  out  1  high in LOAD or RUN.
- done  out  1  high in HALT.

Function
REQ-004 SHALL implement FSM states IDLE, LOAD, RUN, HALT.
REQ-005 IDLE: start=1 -> LOAD next cycle; load counter cleared to 0.
REQ-006 LOAD: load_ready=1; transfer occurs when load_valid & load_ready.
REQ-007 Transfer cycle: mem_we=1, mem_waddr=load counter, mem_wdata=load_data, combinationally; counter increments on that edge.
REQ-008 mem_we SHALL be 0 in every non-transfer cycle and every non-LOAD state.
REQ-009 Transfer with load_last=1 -> RUN; program length register = counter+1 (width D+1); programCounter=0.
REQ-010 Transfer at counter 2**D-1 SHALL be treated as last regardless of load_last (length 2**D).
REQ-011 RUN, stall=1: programCounter and state hold.
REQ-012 RUN, stall=0, priority order: machineCode==all-ones (HALT code) -> HALT, PC holds; else branch_taken -> PC=branch_target; else PC+1==length -> HALT, PC holds; else PC=PC+1 (mod 2**D).
REQ-013 HALT: done=1, PC holds; start=1 -> LOAD, counter cleared.
REQ-014 start SHALL be ignored in LOAD and RUN.
REQ-015 load_valid outside LOAD SHALL be ignored; no write, load_ready=0.
REQ-016 busy, done, load_ready, mem_we SHALL be decoded from state (plus handshake) combinationally, glitch-free from registers.

Reset
REQ-017 reset_n=0 SHALL force immediately: state IDLE, programCounter 0, load counter 0, length 0.
REQ-018 During/after reset until first start: load_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, busy=0, done=0.
REQ-019 Reset mid-LOAD or mid-RUN SHALL abandon operation with no further memory write.

Structure
REQ-020 Shared package SHALL hold state enum type and HALT code constant (all-ones W bits).
REQ-021 SHALL be a single module, no sub-modules; instruction memory external.

Verification
REQ-022 Load 3 words (0x07E,0x0CE,0x1FF, last on third), memory returns them -> writes at 0,1,2; RUN fetches PC 0,1,2; HALT on 0x1FF; done=1, PC=2.
REQ-023 load_valid toggling 1,0,1 with last on second transfer -> exactly 2 writes at addresses 0,1; length=2; RUN reaches PC=1 then HALT by length.
REQ-024 RUN, PC=1, branch_taken=1, branch_target=0xA50 -> PC=0xA50 next cycle; with stall=1 same cycle -> PC stays 1.
REQ-025 D=2, 4 transfers, load_last never set -> 4 writes (addr 0..3), RUN entered after 4th; PC sequence 0,1,2,3 then HALT.
REQ-026 reset_n low for 1 cycle after 2nd word of a 5-word load -> state IDLE, mem_we=0, PC=0; new start reloads from address 0.
REQ-027 HALT, start=1 -> LOAD next cycle, done=0, busy=1, first write at address 0.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// Shared types and constants for the program sequencer: FSM state encoding
// and the instruction word that stops execution.
package program_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } seq_state_e;

    // All-ones word; users slice the low W bits for their instruction width.
    localparam int unsigned HALT_CODE_MAX_W = 64;
    localparam logic [HALT_CODE_MAX_W-1:0] HALT_CODE = '1;

endpackage

// File: rtl/program_sequencer.sv
// Program sequencer: streams a program into external instruction memory,
// then fetches it sequentially with branch/stall control until a halt.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int D = 12,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         load_valid,
    input  logic [W-1:0] load_data,
    input  logic         load_last,
    output logic         load_ready,
    output logic         mem_we,
    output logic [D-1:0] mem_waddr,
    output logic [W-1:0] mem_wdata,
    output logic [D-1:0] programCounter,
    input  logic [W-1:0] machineCode,
    input  logic         branch_taken,
    input  logic [D-1:0] branch_target,
    input  logic         stall,
    output logic         busy,
    output logic         done
);

    // Handshake: a word moves into memory in any cycle where load_valid and
    // load_ready are both high; load_ready depends only on state, never on
    // load_valid, so the producer may hold or withdraw a word freely.

    seq_state_e   state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic [D-1:0] cnt_q, cnt_d;
    logic [D:0]   len_q, len_d;

    logic         xfer;
    logic         cnt_full;
    logic         is_halt_code;
    logic [D:0]   pc_inc;

    always_comb begin
        xfer         = (state_q == ST_LOAD) && load_valid;
        cnt_full     = &cnt_q;
        is_halt_code = (machineCode == HALT_CODE[W-1:0]);
        pc_inc       = {1'b0, pc_q} + (D+1)'(1);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    cnt_d = cnt_q + D'(1);
                    // A full memory ends the load even without load_last.
                    if (load_last || cnt_full) begin
                        state_d = ST_RUN;
                        len_d   = {1'b0, cnt_q} + (D+1)'(1);
                        pc_d    = '0;
                    end
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (is_halt_code) begin
                        state_d = ST_HALT;
                    end else if (branch_taken) begin
                        pc_d = branch_target;
                    end else if (pc_inc == len_q) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_inc[D-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    // Write address/data are zeroed outside a transfer so the bus is quiet.
    always_comb begin
        mem_we         = xfer;
        mem_waddr      = xfer ? cnt_q : '0;
        mem_wdata      = xfer ? load_data : '0;
        load_ready     = (state_q == ST_LOAD);
        busy           = (state_q == ST_LOAD) || (state_q == ST_RUN);
        done           = (state_q == ST_HALT);
        programCounter = pc_q;
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Randomized scoreboard bench for program_sequencer with a cycle-level
// behavioural model and an external instruction memory.
module tb_program_sequencer;

  localparam int D = 12;
  localparam int W = 9;
  localparam int DEPTH = 1 << D;
  localparam int RUN_BUDGET = 20000;
  localparam logic [W-1:0] HALT_W = {W{1'b1}};
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;
  localparam int M_HALT = 3;

  typedef struct packed {
    logic         chk_pc;
    logic [D-1:0] pc;
    logic         busy;
    logic         done;
    logic         ready;
    logic         we;
  } st_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_last = 1'b0;
  logic         load_ready;
  logic         mem_we;
  logic [D-1:0] mem_waddr;
  logic [W-1:0] mem_wdata;
  logic [D-1:0] program_counter;
  logic [W-1:0] machine_code;
  logic         branch_taken = 1'b0;
  logic [D-1:0] branch_target = '0;
  logic         stall = 1'b0;
  logic         busy;
  logic         done;

  program_sequencer #(.D(D), .W(W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_last     (load_last),
    .load_ready    (load_ready),
    .mem_we        (mem_we),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .programCounter(program_counter),
    .machineCode   (machine_code),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .busy          (busy),
    .done          (done)
  );

  // ---------------- clock / external memory ----------------
  always #5 clk = ~clk;

  logic [W-1:0] tb_mem [DEPTH] = '{default: '1};
  always @(posedge clk) if (mem_we) tb_mem[mem_waddr] <= mem_wdata;
  assign machine_code = tb_mem[program_counter];

  // ---------------- scoreboard ----------------
  st_t          exp_st_q[$];
  logic [D+W-1:0] exp_wr_q[$];
  int n_total = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  st_t          mon_e;
  logic [D+W-1:0] mon_w;
  always @(negedge clk) begin
    if (reset_n) begin
      if (exp_st_q.size() > 0) begin
        mon_e = exp_st_q.pop_front();
        check("busy", busy, mon_e.busy);
        check("done", done, mon_e.done);
        check("load_ready", load_ready, mon_e.ready);
        check("mem_we", mem_we, mon_e.we);
        if (mon_e.chk_pc) check("pc", program_counter, mon_e.pc);
      end
      if (mem_we) begin
        if (exp_wr_q.size() == 0) begin
          check("wr_unexpected", mem_we, 1'b0);
        end else begin
          mon_w = exp_wr_q.pop_front();
          check("waddr", mem_waddr, mon_w[D+W-1:W]);
          check("wdata", mem_wdata, mon_w[W-1:0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [W-1:0] model_mem [DEPTH];
  int m_mode = M_IDLE;
  int m_pc = 0;
  int m_cnt = 0;
  int m_len = 0;
  logic [W-1:0] prog_q[$];

  function automatic logic [W-1:0] rand_word();
    return W'($urandom_range(0, (1 << W) - 2));
  endfunction

  // One clock cycle: drive inputs, push the expected response, advance the model.
  task automatic step(input bit s, input bit lv, input logic [W-1:0] ld, input bit ll,
                      input bit st, input bit br, input logic [D-1:0] tgt);
    st_t e;
    @(posedge clk);
    #1;
    start = s; load_valid = lv; load_data = ld; load_last = ll;
    stall = st; branch_taken = br; branch_target = tgt;
    e = '0;
    e.pc = D'(m_pc);
    case (m_mode)
      M_IDLE: begin
        e.chk_pc = 1'b1;
        if (s) begin m_mode = M_LOAD; m_cnt = 0; end
      end
      M_LOAD: begin
        e.busy = 1'b1;
        e.ready = 1'b1;
        if (lv) begin
          e.we = 1'b1;
          exp_wr_q.push_back({D'(m_cnt), ld});
          model_mem[m_cnt] = ld;
          if (ll || m_cnt == DEPTH - 1) begin
            m_len = m_cnt + 1;
            m_pc = 0;
            m_mode = M_RUN;
          end
          m_cnt = (m_cnt + 1) % DEPTH;
        end
      end
      M_RUN: begin
        e.busy = 1'b1;
        e.chk_pc = 1'b1;
        if (!st) begin
          if (model_mem[m_pc] == HALT_W) m_mode = M_HALT;
          else if (br) m_pc = int'(tgt);
          else if (m_pc + 1 == m_len) m_mode = M_HALT;
          else m_pc = (m_pc + 1) % DEPTH;
        end
      end
      default: begin
        e.done = 1'b1;
        e.chk_pc = 1'b1;
        if (s) begin m_mode = M_LOAD; m_cnt = 0; end
      end
    endcase
    exp_st_q.push_back(e);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Start, then offer prog_q with random gaps and ignored start noise.
  task automatic load_prog(input bit mark_last, input int gap_pct);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < prog_q.size(); i++) begin
      while ($urandom_range(0, 99) < gap_pct)
        step($urandom_range(0, 3) == 0, 1'b0, rand_word(), $urandom_range(0, 1), 1'b0, 1'b0, '0);
      step($urandom_range(0, 3) == 0, 1'b1, prog_q[i], mark_last && (i == prog_q.size() - 1),
           1'b0, 1'b0, '0);
    end
  endtask

  task automatic run_until_halt(input int stall_pct, input int br_pct, input int max_br);
    int cycles;
    int nbr;
    bit st;
    bit br;
    logic [D-1:0] tgt;
    cycles = 0;
    nbr = max_br;
    while (m_mode == M_RUN && cycles < RUN_BUDGET) begin
      st = ($urandom_range(0, 99) < stall_pct);
      br = (nbr > 0) && ($urandom_range(0, 99) < br_pct);
      tgt = D'($urandom_range(0, m_len - 1));
      if (br) nbr--;
      step($urandom_range(0, 1), $urandom_range(0, 1), rand_word(), $urandom_range(0, 1), st, br, tgt);
      cycles++;
    end
    if (m_mode == M_RUN) check("run_budget_busy", busy, 1'b0);
    idle_step();
  endtask

  // Asynchronous reset between edges, with a write attempt held during it.
  task automatic reset_mid();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    start = 1'b0;
    load_valid = 1'b1;
    load_data = rand_word();
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", load_ready, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_pc", program_counter, '0);
    check("rst_waddr", mem_waddr, '0);
    check("rst_wdata", mem_wdata, '0);
    m_mode = M_IDLE; m_pc = 0; m_cnt = 0; m_len = 0;
    @(posedge clk);
    #1;
    check("rst_we_hold", mem_we, 1'b0);
    @(negedge clk);
    #2;
    load_valid = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '1;

    reset_mid();
    repeat (2) idle_step();

    // Three-word program ending in the halt code.
    prog_q = '{9'h07E, 9'h0CE, 9'h1FF};
    load_prog(1'b1, 0);
    run_until_halt(0, 0, 0);
    idle_step();

    // Restart from HALT; valid toggles 1,0,1 with last on the second word.
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 9'h011, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 9'h155, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 9'h022, 1'b1, 1'b0, 1'b0, '0);
    run_until_halt(0, 0, 0);

    // Branch at PC=1: first stalled (PC holds), then taken to 0xA50.
    prog_q = '{9'h001, 9'h002, 9'h003, 9'h004};
    load_prog(1'b1, 20);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 12'hA50);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 12'hA50);
    run_until_halt(0, 0, 0);

    // Reset after the second word of a five-word load, then reload.
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 9'h0A1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 9'h0A2, 1'b0, 1'b0, 1'b0, '0);
    reset_mid();
    idle_step();
    prog_q = '{9'h0B1, 9'h0B2, 9'h0B3, 9'h0B4, 9'h0B5};
    load_prog(1'b1, 0);
    run_until_halt(0, 0, 0);

    // Reset in the middle of a run.
    prog_q = '{9'h010, 9'h020, 9'h030, 9'h040, 9'h050, 9'h060};
    load_prog(1'b1, 0);
    repeat (3) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    reset_mid();
    idle_step();

    // Randomized programs with gaps, stalls, branches and embedded halts.
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, 20);
      prog_q.delete();
      for (int i = 0; i < n; i++)
        prog_q.push_back(($urandom_range(0, 9) == 0) ? HALT_W : rand_word());
      load_prog(1'b1, 30);
      run_until_halt(30, 15, 4);
      if ($urandom_range(0, 1) == 1) idle_step();
    end

    // Fill every address without load_last; run ends on the last address.
    prog_q.delete();
    for (int i = 0; i < DEPTH; i++) prog_q.push_back(rand_word());
    load_prog(1'b0, 0);
    run_until_halt(0, 0, 0);
    idle_step();

    repeat (3) @(posedge clk);
    check("st_q_drained", exp_st_q.size(), 0);
    check("wr_q_drained", exp_wr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
